idu_exu_issue_buf: RTL and testbench

//  Issue buffer between the decoder (idu) and the execute unit (exu). Holds up to

---
 rtl/idu_exu_issue_buf.sv | 159 +++++++++++++++
 tb/tb_idu_exu_issue_buf.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/idu_exu_issue_buf.sv
// Issue FIFO between decode and execute. It presents the head entry to exu and flushes younger
// entries on a jump. Buffered rs1/rs2 operands track exu register writeback.
`ifndef DECINFO_WIDTH
`define DECINFO_WIDTH 32
`endif

module idu_exu_issue_buf #(
  parameter int DEPTH         = 2,
  parameter int DECINFO_WIDTH = `DECINFO_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dec_valid_i,
  output logic                     dec_ready_o,
  input  logic [DECINFO_WIDTH-1:0] dec_info_bus_i,
  input  logic [31:0]              dec_imm_i,
  input  logic [31:0]              dec_pc_i,
  input  logic [31:0]              next_pc_i,
  input  logic [4:0]               rd_waddr_i,
  input  logic                     rd_we_i,
  input  logic [4:0]               rs1_raddr_i,
  input  logic [4:0]               rs2_raddr_i,
  input  logic [31:0]              rs1_rdata_i,
  input  logic [31:0]              rs2_rdata_i,
  input  logic                     hold_i,
  input  logic                     jump_i,
  input  logic                     wb_we_i,
  input  logic [4:0]               wb_waddr_i,
  input  logic [31:0]              wb_wdata_i,
  output logic [DECINFO_WIDTH-1:0] exu_dec_info_bus_o,
  output logic [31:0]              exu_dec_imm_o,
  output logic [31:0]              exu_dec_pc_o,
  output logic [31:0]              exu_next_pc_o,
  output logic [4:0]               exu_rd_waddr_o,
  output logic                     exu_rd_we_o,
  output logic [31:0]              exu_reg1_rdata_o,
  output logic [31:0]              exu_reg2_rdata_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DECINFO_WIDTH-1:0] info;
    logic [31:0]              imm;
    logic [31:0]              pc;
    logic [31:0]              npc;
    logic [4:0]               rd;
    logic                     rd_we;
    logic [4:0]               rs1_addr;
    logic [4:0]               rs2_addr;
    logic [31:0]              rs1_data;
    logic [31:0]              rs2_data;
  } entry_t;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  entry_t        push_ent;
  entry_t        head;
  logic          retire;
  logic          push;
  logic          wb_hit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // True when slot idx holds a valid entry that is not the head.
  function automatic logic is_tail(input int idx, input logic [PW-1:0] rd, input logic [CW-1:0] cnt);
    int off;
    off = (idx >= int'(rd)) ? idx - int'(rd) : idx + DEPTH - int'(rd);
    return (off != 0) && (off < int'(cnt));
  endfunction

  assign dec_ready_o = (count_q != CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign retire      = !empty_o && !hold_i;
  assign push        = dec_valid_i && dec_ready_o && !jump_i;
  assign wb_hit      = wb_we_i && (wb_waddr_i != 5'd0);

  always_comb begin
    push_ent          = '0;
    push_ent.info     = dec_info_bus_i;
    push_ent.imm      = dec_imm_i;
    push_ent.pc       = dec_pc_i;
    push_ent.npc      = next_pc_i;
    push_ent.rd       = rd_waddr_i;
    push_ent.rd_we    = rd_we_i;
    push_ent.rs1_addr = rs1_raddr_i;
    push_ent.rs2_addr = rs2_raddr_i;
    // A writeback landing in the same cycle is newer than the regfile read.
    if (rs1_raddr_i == 5'd0)                            push_ent.rs1_data = '0;
    else if (wb_hit && (rs1_raddr_i == wb_waddr_i))     push_ent.rs1_data = wb_wdata_i;
    else                                                push_ent.rs1_data = rs1_rdata_i;
    if (rs2_raddr_i == 5'd0)                            push_ent.rs2_data = '0;
    else if (wb_hit && (rs2_raddr_i == wb_waddr_i))     push_ent.rs2_data = wb_wdata_i;
    else                                                push_ent.rs2_data = rs2_rdata_i;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (push && (wr_ptr_q == PW'(i))) begin
        ent_d[i] = push_ent;
      end else if (wb_hit && is_tail(i, rd_ptr_q, count_q)) begin
        if (ent_q[i].rs1_addr == wb_waddr_i) ent_d[i].rs1_data = wb_wdata_i;
        if (ent_q[i].rs2_addr == wb_waddr_i) ent_d[i].rs2_data = wb_wdata_i;
      end
    end
  end

  always_comb begin
    rd_ptr_d = retire ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (jump_i) begin
      // Only a held head survives a redirect; everything younger is dropped.
      count_d  = (hold_i && !empty_o) ? CW'(1) : '0;
      wr_ptr_d = (count_d != '0) ? ptr_inc(rd_ptr_d) : rd_ptr_d;
    end else begin
      count_d  = count_q + CW'(push) - CW'(retire);
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_q[i] <= ent_d[i];
    end
  end

  assign head = empty_o ? '0 : ent_q[rd_ptr_q];

  assign exu_dec_info_bus_o = head.info;
  assign exu_dec_imm_o      = head.imm;
  assign exu_dec_pc_o       = head.pc;
  assign exu_next_pc_o      = head.npc;
  assign exu_rd_waddr_o     = head.rd;
  assign exu_rd_we_o        = head.rd_we;
  assign exu_reg1_rdata_o   = head.rs1_data;
  assign exu_reg2_rdata_o   = head.rs2_data;

endmodule

// File: tb/tb_idu_exu_issue_buf.sv
// Scoreboard bench for the issue buffer. A queue-level model of the FIFO predicts each
// retirement, and a monitor compares what exu sees.
module tb_idu_exu_issue_buf;
  localparam int DEPTH = 2;

  logic        clk, rst_n;
  logic        dec_valid_i, dec_ready_o;
  logic [31:0] dec_info_bus_i, dec_imm_i, dec_pc_i, next_pc_i;
  logic [4:0]  rd_waddr_i, rs1_raddr_i, rs2_raddr_i, wb_waddr_i;
  logic        rd_we_i, hold_i, jump_i, wb_we_i;
  logic [31:0] rs1_rdata_i, rs2_rdata_i, wb_wdata_i;
  logic [31:0] exu_dec_info_bus_o, exu_dec_imm_o, exu_dec_pc_o, exu_next_pc_o;
  logic [4:0]  exu_rd_waddr_o;
  logic        exu_rd_we_o, empty_o;
  logic [31:0] exu_reg1_rdata_o, exu_reg2_rdata_o;

  idu_exu_issue_buf #(.DEPTH(DEPTH), .DECINFO_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_info_bus_i(dec_info_bus_i), .dec_imm_i(dec_imm_i), .dec_pc_i(dec_pc_i),
    .next_pc_i(next_pc_i), .rd_waddr_i(rd_waddr_i), .rd_we_i(rd_we_i),
    .rs1_raddr_i(rs1_raddr_i), .rs2_raddr_i(rs2_raddr_i),
    .rs1_rdata_i(rs1_rdata_i), .rs2_rdata_i(rs2_rdata_i),
    .hold_i(hold_i), .jump_i(jump_i),
    .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
    .exu_dec_info_bus_o(exu_dec_info_bus_o), .exu_dec_imm_o(exu_dec_imm_o),
    .exu_dec_pc_o(exu_dec_pc_o), .exu_next_pc_o(exu_next_pc_o),
    .exu_rd_waddr_o(exu_rd_waddr_o), .exu_rd_we_o(exu_rd_we_o),
    .exu_reg1_rdata_o(exu_reg1_rdata_o), .exu_reg2_rdata_o(exu_reg2_rdata_o),
    .empty_o(empty_o)
  );

  typedef struct {
    logic [31:0] info, imm, pc, npc;
    logic [4:0]  rd;
    logic        we;
    logic [4:0]  rs1, rs2;
    logic [31:0] d1, d2;
  } ent_t;

  int          total = 0;
  int          bad = 0;
  ent_t        mq[$];
  ent_t        exp_q[$];
  logic [31:0] pc_ctr = 32'h100;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ent_t rand_ent();
    ent_t e;
    e.info = $urandom | 32'h1;
    e.imm  = $urandom;
    e.pc   = pc_ctr;
    e.npc  = pc_ctr + 32'd4;
    pc_ctr = pc_ctr + 32'd4;
    e.rd   = 5'($urandom_range(0, 31));
    e.we   = 1'($urandom_range(0, 1));
    e.rs1  = 5'($urandom_range(0, 3));
    e.rs2  = 5'($urandom_range(0, 3));
    e.d1   = $urandom;
    e.d2   = $urandom;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One cycle of stimulus; the model applies the buffer rules at queue level.
  task automatic step(input ent_t e, input logic v, input logic h, input logic j,
                      input logic wwe, input logic [4:0] wa, input logic [31:0] wd);
    logic ready, ret, psh;
    ent_t ne, tmp;
    @(negedge clk);
    dec_valid_i = v;  hold_i = h;  jump_i = j;
    wb_we_i = wwe;  wb_waddr_i = wa;  wb_wdata_i = wd;
    dec_info_bus_i = e.info;  dec_imm_i = e.imm;  dec_pc_i = e.pc;  next_pc_i = e.npc;
    rd_waddr_i = e.rd;  rd_we_i = e.we;
    rs1_raddr_i = e.rs1;  rs2_raddr_i = e.rs2;
    rs1_rdata_i = e.d1;  rs2_rdata_i = e.d2;
    ready = (mq.size() != DEPTH);
    check("ready", 32'(dec_ready_o), 32'(ready));
    check("empty", 32'(empty_o), 32'(mq.size() == 0));
    ret = (mq.size() > 0) && !h;
    psh = v && ready && !j;
    if (ret) exp_q.push_back(mq[0]);
    if (wwe && wa != 5'd0) begin
      for (int i = 1; i < mq.size(); i++) begin
        tmp = mq[i];
        if (tmp.rs1 == wa) tmp.d1 = wd;
        if (tmp.rs2 == wa) tmp.d2 = wd;
        mq[i] = tmp;
      end
    end
    ne = e;
    ne.d1 = (e.rs1 == 5'd0) ? 32'd0 : (wwe && wa != 5'd0 && e.rs1 == wa) ? wd : e.d1;
    ne.d2 = (e.rs2 == 5'd0) ? 32'd0 : (wwe && wa != 5'd0 && e.rs2 == wa) ? wd : e.d2;
    if (j) begin
      if (h && mq.size() > 0) begin
        tmp = mq[0];
        mq.delete();
        mq.push_back(tmp);
      end else begin
        mq.delete();
      end
    end else begin
      if (ret) void'(mq.pop_front());
      if (psh) mq.push_back(ne);
    end
    $display("cycle v=%0b h=%0b j=%0b pc=%h push=%0b retire=%0b occ=%0d",
             v, h, j, e.pc, psh, ret, mq.size());
  endtask

  // Monitor: any head that exu consumes must match the next predicted retirement.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (!empty_o && !hold_i) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL retire_unexpected actual pc=%h required=no retire", exu_dec_pc_o);
          end else begin
            e = exp_q.pop_front();
            if ({exu_dec_info_bus_o, exu_dec_imm_o, exu_dec_pc_o, exu_next_pc_o, exu_rd_waddr_o,
                 exu_rd_we_o, exu_reg1_rdata_o, exu_reg2_rdata_o} !==
                {e.info, e.imm, e.pc, e.npc, e.rd, e.we, e.d1, e.d2}) begin
              bad++;
              $display("FAIL retire actual pc=%h r1=%h r2=%h rd=%h info=%h required pc=%h r1=%h r2=%h rd=%h info=%h",
                       exu_dec_pc_o, exu_reg1_rdata_o, exu_reg2_rdata_o, exu_rd_waddr_o,
                       exu_dec_info_bus_o, e.pc, e.d1, e.d2, e.rd, e.info);
            end else begin
              $display("retire pc=%h r1=%h r2=%h ok", e.pc, e.d1, e.d2);
            end
          end
        end else if (empty_o) begin
          check("bubble", exu_dec_info_bus_o | exu_dec_pc_o | exu_reg1_rdata_o |
                exu_reg2_rdata_o | exu_dec_imm_o | exu_next_pc_o |
                32'(exu_rd_waddr_o) | 32'(exu_rd_we_o), 32'd0);
        end
      end
    end
  end

  initial begin
    ent_t e;
    ent_t idle;
    rst_n = 1'b0;  dec_valid_i = 1'b0;  hold_i = 1'b0;  jump_i = 1'b0;  wb_we_i = 1'b0;
    wb_waddr_i = '0;  wb_wdata_i = '0;  dec_info_bus_i = '0;  dec_imm_i = '0;  dec_pc_i = '0;
    next_pc_i = '0;  rd_waddr_i = '0;  rd_we_i = 1'b0;  rs1_raddr_i = '0;  rs2_raddr_i = '0;
    rs1_rdata_i = '0;  rs2_rdata_i = '0;
    idle = '{default: '0};
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_ready", 32'(dec_ready_o), 32'd1);
    check("rst_info", exu_dec_info_bus_o, 32'd0);
    check("rst_pc", exu_dec_pc_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Push into an empty buffer appears at the head one edge later.
    e = rand_ent();  e.pc = 32'h100;
    step(e, 1, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("t1_pc", exu_dec_pc_o, 32'h100);
    check("t1_empty", 32'(empty_o), 32'd0);

    // Held head fills the buffer; the third instruction sees ready low.
    step(rand_ent(), 1, 1, 0, 0, 0, 0);
    step(rand_ent(), 1, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("t2_ready", 32'(dec_ready_o), 32'd0);

    // Jump: head retires, younger entry and same-cycle push are dropped.
    step(rand_ent(), 1, 0, 1, 0, 0, 0);
    @(posedge clk); #1;
    check("t3_empty", 32'(empty_o), 32'd1);

    // Writeback to x5 reaches a buffered reader and a same-cycle push.
    e = rand_ent();  e.rd = 5'd5;  e.we = 1'b1;
    step(e, 1, 1, 0, 0, 0, 0);
    e = rand_ent();  e.rs1 = 5'd5;  e.d1 = 32'h1111;
    step(e, 1, 1, 0, 0, 0, 0);
    step(idle, 0, 1, 0, 1, 5'd5, 32'hDEADBEEF);
    e = rand_ent();  e.rs1 = 5'd5;  e.d1 = 32'h2222;
    step(e, 1, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("t4_bypass_buf", exu_reg1_rdata_o, 32'hDEADBEEF);
    step(e, 1, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("t4_bypass_push", exu_reg1_rdata_o, 32'hDEADBEEF);
    step(idle, 0, 0, 0, 0, 0, 0);

    // Writes to x0 never reach an x0 operand.
    e = rand_ent();  e.rs1 = 5'd0;  e.d1 = 32'h5555;
    step(e, 1, 1, 0, 1, 5'd0, 32'h1234);
    @(posedge clk); #1;
    check("t5_x0", exu_reg1_rdata_o, 32'd0);
    step(idle, 0, 0, 0, 0, 0, 0);

    // Streaming push and retire across several pointer wraps.
    for (int i = 0; i < 3 * DEPTH + 2; i++) step(rand_ent(), 1, 0, 0, 0, 0, 0);
    step(idle, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_empty", 32'(empty_o), 32'd1);
        check("midrst_out", exu_dec_pc_o | exu_dec_info_bus_o | exu_reg1_rdata_o, 32'd0);
        mq.delete();
        dec_valid_i = 1'b0;  hold_i = 1'b0;  jump_i = 1'b0;  wb_we_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      step(rand_ent(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), $urandom);
    end
    step(idle, 0, 0, 0, 0, 0, 0);
    step(idle, 0, 0, 0, 0, 0, 0);
    step(idle, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
